instruction_loader: RTL and testbench

Boot-time writer for the byte-addressed instruction memory: accepts a length-prefixed program image as a byte stream over a valid/ready handshake and writes it into instruction memory starting at address 0. It holds the pipeline in reset (`cpu_hold`) until the image is completely written, then releases it. It sits between the host/debug byte source and the instruction memory write port; the fetch stage is the only reader.

---
 rtl/instruction_loader_pkg.sv | 31 +++
 rtl/loader_checksum.sv | 26 ++
 rtl/instruction_loader.sv | 152 +++++++++++++++
 tb/tb_instruction_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Fallback values for the memory geometry; the project normally supplies them from defines.v.
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif
`ifndef INSTRUCTION_MEM_SIZE
`define INSTRUCTION_MEM_SIZE 1024
`endif

package instruction_loader_pkg;

    localparam int unsigned LEN_W           = 16;
    localparam int unsigned BYTES_PER_INSTR = 4;
    localparam int unsigned CNT_W           = LEN_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // Payload size in bytes for an instruction count taken from the header.
    function automatic logic [CNT_W-1:0] image_bytes(input logic [LEN_W-1:0] n);
        return CNT_W'(n) * CNT_W'(BYTES_PER_INSTR);
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// Clearable running XOR over the payload bytes, compared against a trailing byte.
module loader_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    input  logic [7:0] expected,
    output logic       match_c
);

    logic [7:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ data;
        end
    end

    assign match_c = (acc == expected);

endmodule

// File: rtl/instruction_loader.sv
// Writes a length-prefixed byte-stream image into instruction memory and holds the CPU until done.
// Optional trailing XOR checksum is compiled in with LOADER_CHECKSUM_EN.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned MEM_SIZE = `INSTRUCTION_MEM_SIZE,
    parameter int unsigned ADDR_W   = `INSTRUCTION_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [7:0]        mem_wr_byte,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_LOAD = CHECK;
`else
    localparam state_t AFTER_LOAD = DONE;
`endif

    state_t            state, state_next;
    logic [7:0]        len_hi, len_hi_next;
    logic [CNT_W-1:0]  left, left_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic              wr_en_next;
    logic [ADDR_W-1:0] wr_addr_next;
    logic [7:0]        wr_byte_next;
    logic [CNT_W-1:0]  total_c;
    logic              accept_c;

    assign accept_c = in_valid && in_ready;
    assign total_c  = image_bytes({len_hi, in_data});

`ifdef LOADER_CHECKSUM_EN
    logic ck_clr, ck_en, ck_match;

    loader_checksum u_checksum (
        .clk      (clk),
        .rst      (rst),
        .clr      (ck_clr),
        .en       (ck_en),
        .data     (in_data),
        .expected (in_data),
        .match_c  (ck_match)
    );
`endif

    // Next-state, counters and write-port values.
    always_comb begin
        state_next   = state;
        len_hi_next  = len_hi;
        left_next    = left;
        addr_next    = addr;
        wr_en_next   = 1'b0;
        wr_addr_next = mem_wr_addr;
        wr_byte_next = mem_wr_byte;
`ifdef LOADER_CHECKSUM_EN
        ck_clr       = 1'b0;
        ck_en        = 1'b0;
`endif
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next = LEN_HI;
                    addr_next  = '0;
`ifdef LOADER_CHECKSUM_EN
                    ck_clr     = 1'b1;
`endif
                end
            end
            LEN_HI: begin
                if (accept_c) begin
                    len_hi_next = in_data;
                    state_next  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept_c) begin
                    left_next = total_c;
                    if (total_c == CNT_W'(0)) begin
                        state_next = AFTER_LOAD;
                    end else if (32'(total_c) > MEM_SIZE) begin
                        state_next = ERROR;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept_c) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = addr;
                    wr_byte_next = in_data;
                    addr_next    = addr + ADDR_W'(1);
                    left_next    = left - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    ck_en        = 1'b1;
`endif
                    if (left == CNT_W'(1)) begin
                        state_next = AFTER_LOAD;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept_c) begin
                    state_next = ck_match ? DONE : ERROR;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they change on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len_hi      <= '0;
            left        <= '0;
            addr        <= '0;
            in_ready    <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_byte <= '0;
            cpu_hold    <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_next;
            len_hi      <= len_hi_next;
            left        <= left_next;
            addr        <= addr_next;
            in_ready    <= state_next inside {LEN_HI, LEN_LO, LOAD, CHECK};
            mem_wr_en   <= wr_en_next;
            mem_wr_addr <= wr_addr_next;
            mem_wr_byte <= wr_byte_next;
            cpu_hold    <= (state_next != DONE);
            done        <= (state_next == DONE);
            error       <= (state_next == ERROR);
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader; adapts to LOADER_CHECKSUM_EN.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [7:0]  mem_wr_byte;
    logic        cpu_hold;
    logic        done;
    logic        error;

    instruction_loader #(
        .MEM_SIZE (1024),
        .ADDR_W   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_byte (mem_wr_byte),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_count = 0;
    logic [31:0] last_addr = '0;
    wr_t         exp_q[$];
    logic [7:0]  img[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (mem_wr_en === 1'b1) begin
            wr_count++;
            last_addr = mem_wr_addr;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0h byte %0h, expected no write",
                         mem_wr_addr, mem_wr_byte);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_wr_addr, e.addr);
                check("wr_byte", 32'(mem_wr_byte), 32'(e.data));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int cnt = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (1) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            cnt++;
            if (cnt > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Header, payload from img (expectations queued per byte), then checksum when compiled in.
    task automatic run_image(input logic [15:0] n, input bit bad_ck, input bit gaps);
        logic [7:0] x = 8'h00;
        logic [7:0] ck;
        send(n[15:8]);
        send(n[7:0]);
        for (int k = 0; k < img.size(); k++) begin
            exp_q.push_back({32'(k), img[k]});
            x ^= img[k];
            send(img[k]);
            if (gaps) idle_cycle();
        end
        ck = bad_ck ? (x ^ 8'h0F) : x;
`ifdef LOADER_CHECKSUM_EN
        send(ck);
`else
        if (ck == 8'hFF) x = 8'h00;
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),    32'd0);
        check({tag, "_wr_en"},     32'(mem_wr_en),   32'd0);
        check({tag, "_wr_addr"},   mem_wr_addr,      32'd0);
        check({tag, "_wr_byte"},   32'(mem_wr_byte), 32'd0);
        check({tag, "_cpu_hold"},  32'(cpu_hold),    32'd1);
        check({tag, "_done"},      32'(done),        32'd0);
        check({tag, "_error"},     32'(error),       32'd0);
    endtask

    task automatic check_status(input string tag, input bit d, input bit e, input bit h);
        check({tag, "_done"},     32'(done),     32'(d));
        check({tag, "_error"},    32'(error),    32'(e));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
    endtask

    task automatic drain(input string tag, input int w0, input int nwr);
        repeat (3) @(negedge clk);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_wr_count"}, 32'(wr_count - w0), 32'(nwr));
    endtask

    initial begin
        int w0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single instruction
        w0 = wr_count;
        img = '{8'hE3, 8'hA0, 8'h00, 8'h14};
        pulse_start();
        run_image(16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        check_status("single", 1'b1, 1'b0, 1'b0);
        drain("single", w0, 4);

`ifdef LOADER_CHECKSUM_EN
        // Corrupted checksum (0x58 instead of 0x57)
        w0 = wr_count;
        pulse_start();
        run_image(16'h0001, 1'b1, 1'b0);
        @(negedge clk);
        check_status("badck", 1'b0, 1'b1, 1'b1);
        drain("badck", w0, 4);
`endif

        // Empty image
        w0 = wr_count;
        img.delete();
        pulse_start();
        run_image(16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        check_status("empty", 1'b1, 1'b0, 1'b0);
        drain("empty", w0, 0);

        // Oversize: 0x0101 instructions = 1028 bytes > 1024
        w0 = wr_count;
        pulse_start();
        send(8'h01);
        send(8'h01);
        @(negedge clk);
        check_status("oversize", 1'b0, 1'b1, 1'b1);
        check("oversize_in_ready", 32'(in_ready), 32'd0);
        drain("oversize", w0, 0);

        // Exactly fills memory
        w0 = wr_count;
        img.delete();
        for (int k = 0; k < 1024; k++) img.push_back(8'(k * 7 + 3));
        pulse_start();
        run_image(16'h0100, 1'b0, 1'b0);
        @(negedge clk);
        check_status("full", 1'b1, 1'b0, 1'b0);
        drain("full", w0, 1024);
        check("full_last_addr", last_addr, 32'd1023);

        // Start from DONE, then 8 bytes with in_valid gaps
        w0 = wr_count;
        pulse_start();
        check_status("restart", 1'b0, 1'b0, 1'b1);
        check("restart_in_ready", 32'(in_ready), 32'd1);
        img.delete();
        for (int k = 0; k < 8; k++) img.push_back(8'h10 + 8'(k));
        run_image(16'h0002, 1'b0, 1'b1);
        @(negedge clk);
        check_status("gaps", 1'b1, 1'b0, 1'b0);
        drain("gaps", w0, 8);
        check("gaps_last_addr", last_addr, 32'd7);

        // Reset right after payload byte 2 is accepted; its write is dropped
        w0 = wr_count;
        pulse_start();
        send(8'h00);
        send(8'h01);
        exp_q.push_back({32'd0, 8'hAA});
        send(8'hAA);
        exp_q.push_back({32'd1, 8'hBB});
        send(8'hBB);
        send(8'hCC);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        check("midrst_wr_en_hold", 32'(mem_wr_en), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drain("midrst", w0, 2);

        // Full reload from address 0 after the reset
        w0 = wr_count;
        img = '{8'h12, 8'h34, 8'h56, 8'h78};
        pulse_start();
        run_image(16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        check_status("reload", 1'b1, 1'b0, 1'b0);
        drain("reload", w0, 4);

        // Second image overwrites from address 0 after DONE
        w0 = wr_count;
        pulse_start();
        check_status("redo", 1'b0, 1'b0, 1'b1);
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        run_image(16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        check_status("overwrite", 1'b1, 1'b0, 1'b0);
        drain("overwrite", w0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
